fp_op_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the fixed-point arithmetic core (add/mul/div, Q8.23 in 32 bits).
- Buffers incoming operations in a small FIFO and issues them to the core one at a time, holding operands stable.
- Waits for the fixed add/mul latency, or for the divider's completion flag, then returns a tagged, error-flagged result over a valid/ready interface.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_cmd_fifo.sv | 63 ++++++
 rtl/fp_op_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fp_op_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ============================================================================
// fp_pkg : shared opcodes, error codes, FSM states and Q8.23 format constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 23;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_AM  = 3'd2,
    ST_WAIT_DIV = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fp_cmd_fifo.sv
// ============================================================================
// fp_cmd_fifo : synchronous command FIFO with registered occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_cmd_fifo #(
  parameter int DW    = 72,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          w_push;
  logic          w_pop;

  // Full refuses a push even when a pop lands in the same cycle.
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_op_sequencer.sv
// ============================================================================
// fp_op_sequencer : buffers commands, issues them one at a time to the
// fixed-point core and returns tagged, error-flagged results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_op_sequencer #(
  parameter int WIDTH       = fp_pkg::WIDTH,
  parameter int DEPTH       = 4,
  parameter int AM_LAT      = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_opcode,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [3:0]             in_tag,
  output logic [1:0]             core_opcode,
  output logic [WIDTH-1:0]       core_a,
  output logic [WIDTH-1:0]       core_b,
  output logic                   core_start,
  input  logic [WIDTH-1:0]       core_result,
  input  logic                   core_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [3:0]             out_tag,
  output logic [1:0]             out_err,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import fp_pkg::*;

  localparam int DW      = 2 + 2*WIDTH + 4;
  localparam int CNT_MAX = (AM_LAT > DIV_TIMEOUT) ? AM_LAT : DIV_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       tag_q, tag_d;
  logic [1:0]       core_op_q, core_op_d;
  logic [WIDTH-1:0] core_a_q, core_a_d;
  logic [WIDTH-1:0] core_b_q, core_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       err_q, err_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_rdata;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [3:0]       head_tag;

  fp_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata ({in_opcode, in_a, in_b, in_tag}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_op  = fifo_rdata[DW-1 -: 2];
  assign head_a   = fifo_rdata[4+WIDTH +: WIDTH];
  assign head_b   = fifo_rdata[4 +: WIDTH];
  assign head_tag = fifo_rdata[3:0];

  assign in_ready    = !fifo_full;
  assign core_opcode = core_op_q;
  assign core_a      = core_a_q;
  assign core_b      = core_b_q;
  assign core_start  = (state_q == ST_ISSUE) && (op_q != OP_RSVD);
  assign out_valid   = (state_q == ST_RESP);
  assign out_result  = res_q;
  assign out_tag     = tag_q;
  assign out_err     = err_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    core_op_d = core_op_q;
    core_a_d  = core_a_q;
    core_b_d  = core_b_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_op;
          tag_d    = head_tag;
          // Core operands only change for a command that will really issue.
          if (head_op != OP_RSVD) begin
            core_op_d = head_op;
            core_a_d  = head_a;
            core_b_d  = head_b;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_RSVD) begin
          res_d   = '0;
          err_d   = ERR_ILLEGAL;
          state_d = ST_RESP;
        end else if (op_q == OP_DIV) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DIV;
        end else begin
          cnt_d   = CNT_W'(AM_LAT);
          state_d = ST_WAIT_AM;
        end
      end
      ST_WAIT_AM: begin
        if (cnt_q <= CNT_W'(1)) begin
          res_d   = core_result;
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_DIV: begin
        // A completion flag on the last allowed cycle beats the timeout.
        if (core_done) begin
          res_d   = core_result;
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      core_op_q <= '0;
      core_a_q  <= '0;
      core_b_q  <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      core_op_q <= core_op_d;
      core_a_q  <= core_a_d;
      core_b_q  <= core_b_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_op_sequencer.sv
// ============================================================================
// tb_fp_op_sequencer : scoreboard bench with a stub core and a command-level
// reference model of the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_op_sequencer;

  localparam int W           = 32;
  localparam int DEPTH       = 4;
  localparam int AM_LAT      = 1;
  localparam int DIV_TIMEOUT = 64;
  localparam int NEVER       = 1000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [1:0]             in_opcode = '0;
  logic [W-1:0]           in_a = '0;
  logic [W-1:0]           in_b = '0;
  logic [3:0]             in_tag = '0;
  logic [1:0]             core_opcode;
  logic [W-1:0]           core_a;
  logic [W-1:0]           core_b;
  logic                   core_start;
  logic [W-1:0]           core_result = '0;
  logic                   core_done = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [W-1:0]           out_result;
  logic [3:0]             out_tag;
  logic [1:0]             out_err;
  logic [$clog2(DEPTH):0] fifo_count;

  fp_op_sequencer #(
    .WIDTH       (W),
    .DEPTH       (DEPTH),
    .AM_LAT      (AM_LAT),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .core_opcode (core_opcode),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_start  (core_start),
    .core_result (core_result),
    .core_done   (core_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_err     (out_err),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] res; logic [3:0] tag; logic [1:0] err; int lat; } exp_t;
  typedef struct { logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; } iss_t;
  typedef struct { int dly; logic [W-1:0] res; } div_t;

  exp_t sb_q[$];
  iss_t iss_q[$];
  div_t div_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rdy_mode = 0;   // 0 hold low, 1 hold high, 2 random
  bit   noise_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Command-level model: what the consumer must see for one command, and how
  // many cycles after core_start the result must appear (-1 if never issued).
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] tag, input int dly, input logic [W-1:0] dres);
    exp_t e;
    e.tag = tag;
    e.err = 2'b00;
    e.lat = AM_LAT + 1;
    e.res = '0;
    case (op)
      2'b00: e.res = a + b;
      2'b01: e.res = a * b;
      2'b10: begin
        if (dly <= DIV_TIMEOUT) begin
          e.res = dres;
          e.lat = dly + 1;
        end else begin
          e.err = 2'b10;
          e.lat = DIV_TIMEOUT + 1;
        end
      end
      default: begin
        e.err = 2'b01;
        e.lat = -1;
      end
    endcase
    return e;
  endfunction

  task automatic record(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] tag, input int dly, input logic [W-1:0] dres);
    iss_t is;
    div_t dv;
    sb_q.push_back(model(op, a, b, tag, dly, dres));
    if (op != 2'b11) begin
      is.op = op; is.a = a; is.b = b;
      iss_q.push_back(is);
    end
    if (op == 2'b10) begin
      dv.dly = dly; dv.res = dres;
      div_q.push_back(dv);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] tag, input int dly, input logic [W-1:0] dres);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
    else record(op, a, b, tag, dly, dres);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stub core: add/mul answer AM_LAT cycles after start, divide raises
  // core_done a programmed number of cycles after start (or not at all).
  initial begin
    bit   pend;
    int   k;
    div_t cur;
    iss_t is;
    pend = 1'b0; k = 0; cur.dly = 0; cur.res = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          k++;
          if (k == cur.dly) begin
            core_done   = 1'b1;
            core_result = cur.res;
            pend        = 1'b0;
          end else if (k > DIV_TIMEOUT + 1) begin
            pend = 1'b0;
          end
        end else if (noise_en && $urandom_range(0, 7) == 0) begin
          core_done = 1'b1;
        end
        if (core_start) begin
          start_cyc = cyc;
          chk("start_during_resp", 64'(out_valid), 64'd0);
          if (iss_q.size() == 0) begin
            chk("spurious_start", 64'(core_start), 64'd0);
          end else begin
            is = iss_q.pop_front();
            chk("core_opcode", 64'(core_opcode), 64'(is.op));
            chk("core_a", 64'(core_a), 64'(is.a));
            chk("core_b", 64'(core_b), 64'(is.b));
          end
          case (core_opcode)
            2'b00: core_result = core_a + core_b;
            2'b01: core_result = core_a * core_b;
            2'b10: begin
              if (div_q.size() != 0) begin
                cur  = div_q.pop_front();
                pend = 1'b1;
                k    = 0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: every cycle a result is offered it must match the queue head.
  initial begin
    bit   prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q[0];
          chk("out_result", 64'(out_result), 64'(e.res));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_err", 64'(out_err), 64'(e.err));
          if (!prev_valid && e.lat >= 0)
            chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      prev_valid = rst_n && out_valid;
    end
  end

  initial begin
    int n;
    int acc;
    logic [1:0] op;
    int dly;

    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add, push-to-result timing.
    rdy_mode = 1;
    send(2'b00, 32'h0080_0000, 32'h0100_0000, 4'd3, 0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("push_to_valid", 64'(n), 64'd4);
    drain();

    // Fill FIFO with the consumer stalled.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_opcode = 2'b00;
      in_a = 32'h10 * (i + 1); in_b = 32'h3; in_tag = 4'(i);
      @(negedge clk);
      if (in_ready) begin
        acc++;
        record(2'b00, in_a, in_b, in_tag, 0, '0);
      end
      if (i == 5) chk("full_refuse", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accepted", 64'(acc), 64'd5);
    chk("fifo_count_full", 64'(fifo_count), 64'(DEPTH));
    rdy_mode = 1;
    drain();

    // Divides: normal completion, coincident with timeout, timeout.
    send(2'b10, 32'h0300_0000, 32'h0100_0000, 4'd5, 20, 32'h0180_0000);
    drain();
    send(2'b10, 32'h0300_0000, 32'h0100_0000, 4'd6, NEVER, 32'h0);
    drain();
    send(2'b10, 32'h0123_4567, 32'h0000_0100, 4'd7, DIV_TIMEOUT, 32'hCAFE_0001);
    drain();
    send(2'b10, 32'h0123_4567, 32'h0000_0100, 4'd8, DIV_TIMEOUT + 1, 32'hCAFE_0002);
    drain();

    // Reserved opcode, with stray core_done pulses around it.
    noise_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_done_ignored", 64'(out_valid), 64'd0);
    send(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 4'd9, 0, '0);
    drain();

    // Stalled result stays put and blocks the next issue.
    rdy_mode = 0;
    send(2'b01, 32'h0000_0123, 32'h0000_0456, 4'd10, 0, '0);
    send(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd11, 0, '0);
    repeat (10) @(negedge clk);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_fifo_count", 64'(fifo_count), 64'd1);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    drain();

    // Randomized traffic.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, DIV_TIMEOUT + 2));
      send(op, $urandom, $urandom, 4'($urandom), dly, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Reset mid-run with a result pending and commands queued.
    rdy_mode = 0;
    send(2'b00, 32'h1, 32'h2, 4'd1, 0, '0);
    send(2'b00, 32'h3, 32'h4, 4'd2, 0, '0);
    send(2'b01, 32'h5, 32'h6, 4'd3, 0, '0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_core_start", 64'(core_start), 64'd0);
    chk("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_result", 64'(out_result), 64'd0);
    sb_q.delete();
    iss_q.delete();
    div_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    repeat (8) @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_fifo", 64'(fifo_count), 64'd0);
    @(posedge clk);
    #1;
    send(2'b00, 32'h0080_0000, 32'h0080_0000, 4'd12, 0, '0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
